// File: rtl/mem_axi_pkg.sv
// mem_axi_pkg: shared types and constants for the native-to-AXI4-lite initiator
//   state_t      : initiator FSM states
//   PROT_DATA    : AxPROT for data accesses (unprivileged, secure, data)
//   PROT_INSTR   : AxPROT for instruction fetches (bit 2 = instruction)
//   TIMEOUT_FILL : read data returned when a transaction times out
package mem_axi_pkg;

   typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, DONE} state_t;

   localparam logic [2:0]  PROT_DATA    = 3'b000;
   localparam logic [2:0]  PROT_INSTR   = 3'b100;
   localparam logic [31:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_axi_watchdog.sv
// mem_axi_watchdog: response-wait timer, present only when MEM_AXI_TIMEOUT_EN is defined
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : synchronous clear, wins over enable
//   enable      : count one per cycle while high
//   expired     : high in the TIMEOUT_CYCLES-th enabled cycle since the last clear
`ifdef MEM_AXI_TIMEOUT_EN
module mem_axi_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)     count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= count + 1'b1;
   end

   // expiry forces the initiator out of its wait states, so count never wraps
   assign expired = enable && count == W'(TIMEOUT_CYCLES - 1);

endmodule
`endif

// File: rtl/mem_axi_initiator.sv
// mem_axi_initiator: bridges a native valid/ready memory request onto an AXI4-lite master
//   clk, resetn       : clock, asynchronous active-low reset
//   mem_valid/instr/addr/wdata/wstrb : native request, wstrb != 0 selects a write
//   mem_ready, mem_rdata : one-cycle completion pulse and read data
//   mem_axi_aw*/w*/b*/ar*/r* : AXI4-lite master channels, one transaction in flight
//   bus_err           : sticky response-timeout flag
//   Macro MEM_AXI_TIMEOUT_EN adds a TIMEOUT_CYCLES response-wait watchdog; without it
//   waits are unbounded and bus_err is tied low.
module mem_axi_initiator #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        mem_axi_awvalid,
   input  logic        mem_axi_awready,
   output logic [31:0] mem_axi_awaddr,
   output logic [2:0]  mem_axi_awprot,
   output logic        mem_axi_wvalid,
   input  logic        mem_axi_wready,
   output logic [31:0] mem_axi_wdata,
   output logic [3:0]  mem_axi_wstrb,
   input  logic        mem_axi_bvalid,
   output logic        mem_axi_bready,
   output logic        mem_axi_arvalid,
   input  logic        mem_axi_arready,
   output logic [31:0] mem_axi_araddr,
   output logic [2:0]  mem_axi_arprot,
   input  logic        mem_axi_rvalid,
   output logic        mem_axi_rready,
   input  logic [31:0] mem_axi_rdata,
   output logic        bus_err
);

   import mem_axi_pkg::*;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t      state;
   logic [29:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        instr_q;
   logic        expired;

   // word-aligned addresses: the byte offset is carried by wstrb only
   assign mem_axi_awaddr = {addr_q, 2'b00};
   assign mem_axi_araddr = {addr_q, 2'b00};
   assign mem_axi_awprot = PROT_DATA;
   assign mem_axi_arprot = instr_q ? PROT_INSTR : PROT_DATA;
   assign mem_axi_wdata  = wdata_q;
   assign mem_axi_wstrb  = wstrb_q;

`ifdef MEM_AXI_TIMEOUT_EN
   mem_axi_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk     (clk),
      .resetn  (resetn),
      .clear   (state == DONE),
      .enable  (state inside {WRITE, WRESP, READ, RDATA}),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      bus_err <= 1'b0;
      else if (expired) bus_err <= 1'b1;
   end
`else
   assign expired = 1'b0;
   assign bus_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state           <= IDLE;
         addr_q          <= '0;
         wdata_q         <= '0;
         wstrb_q         <= '0;
         instr_q         <= 1'b0;
         mem_ready       <= 1'b0;
         mem_rdata       <= '0;
         mem_axi_awvalid <= 1'b0;
         mem_axi_wvalid  <= 1'b0;
         mem_axi_bready  <= 1'b0;
         mem_axi_arvalid <= 1'b0;
         mem_axi_rready  <= 1'b0;
      end else begin
         mem_ready <= 1'b0;
         if (expired) begin
            // abandon the bus transaction and complete the native request with fill data
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b0;
            mem_rdata       <= TIMEOUT_FILL;
            mem_ready       <= 1'b1;
            state           <= DONE;
         end else begin
            case (state)
               IDLE: if (mem_valid) begin
                  addr_q  <= mem_addr[31:2];
                  wdata_q <= mem_wdata;
                  wstrb_q <= mem_wstrb;
                  instr_q <= mem_instr;
                  if (|mem_wstrb) begin
                     mem_axi_awvalid <= 1'b1;
                     mem_axi_wvalid  <= 1'b1;
                     state           <= WRITE;
                  end else begin
                     mem_axi_arvalid <= 1'b1;
                     state           <= READ;
                  end
               end
               WRITE: begin
                  // address and data channels retire independently, in either order
                  if (mem_axi_awready) mem_axi_awvalid <= 1'b0;
                  if (mem_axi_wready)  mem_axi_wvalid  <= 1'b0;
                  if ((!mem_axi_awvalid || mem_axi_awready) && (!mem_axi_wvalid || mem_axi_wready)) begin
                     mem_axi_bready <= 1'b1;
                     state          <= WRESP;
                  end
               end
               WRESP: if (mem_axi_bvalid) begin
                  mem_axi_bready <= 1'b0;
                  mem_ready      <= 1'b1;
                  state          <= DONE;
               end
               READ: if (mem_axi_arready) begin
                  mem_axi_arvalid <= 1'b0;
                  mem_axi_rready  <= 1'b1;
                  state           <= RDATA;
               end
               RDATA: if (mem_axi_rvalid) begin
                  mem_axi_rready <= 1'b0;
                  mem_rdata      <= mem_axi_rdata;
                  mem_ready      <= 1'b1;
                  state          <= DONE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_axi_initiator.sv
// tb_mem_axi_initiator: self-checking bench for mem_axi_initiator (vectors, corner sequences, random traffic)
module tb_mem_axi_initiator;

   localparam int TO = 16;
`ifdef MEM_AXI_TIMEOUT_EN
   localparam int MAXD = 3;
`else
   localparam int MAXD = 7;
`endif

   logic        clk = 1'b0, resetn = 1'b0;
   logic        mem_valid = 1'b0, mem_instr = 1'b0;
   logic [31:0] mem_addr = '0, mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_axi_awvalid, mem_axi_awready = 1'b0;
   logic [31:0] mem_axi_awaddr;
   logic [2:0]  mem_axi_awprot;
   logic        mem_axi_wvalid, mem_axi_wready = 1'b0;
   logic [31:0] mem_axi_wdata;
   logic [3:0]  mem_axi_wstrb;
   logic        mem_axi_bvalid = 1'b0, mem_axi_bready;
   logic        mem_axi_arvalid, mem_axi_arready = 1'b0;
   logic [31:0] mem_axi_araddr;
   logic [2:0]  mem_axi_arprot;
   logic        mem_axi_rvalid = 1'b0, mem_axi_rready;
   logic [31:0] mem_axi_rdata = '0;
   logic        bus_err;

   always #5 clk = ~clk;

   mem_axi_initiator #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
      .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
      .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
      .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
      .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
      .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
      .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
      .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
      .mem_axi_rdata(mem_axi_rdata), .bus_err(bus_err)
   );

   int tests = 0, fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // AXI slave model: word memory plus per-transaction handshake delays
   logic [31:0] smem [16];
   int aw_d, w_d, b_d, ar_d, r_d, aw_n, w_n, b_n, ar_n, r_n;
   int aw_hs, w_hs, b_hs, ar_hs, r_hs;
   bit aw_done, w_done, ar_done, b_sent, r_sent;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0]  cap_wstrb;
   logic [2:0]  cap_awprot, cap_arprot;
   logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr;
   logic [31:0] p_awaddr, p_wdata, p_araddr;
   logic [3:0]  p_wstrb;
   logic [2:0]  p_awprot, p_arprot;

   task automatic slave_clear(input int awd, input int wd, input int bd, input int ard, input int rd);
      aw_d = awd; w_d = wd; b_d = bd; ar_d = ard; r_d = rd;
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      aw_done = 0; w_done = 0; ar_done = 0; b_sent = 0; r_sent = 0;
      mem_axi_awready = 0; mem_axi_wready = 0; mem_axi_arready = 0;
      mem_axi_bvalid = 0; mem_axi_rvalid = 0;
      {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr} = '0;
   endtask

   // called once per negedge: detect handshakes of the edge just passed, check hold rules, drive slave
   task automatic slave_step();
      if (p_awv && p_awr) begin
         aw_done = 1; aw_hs++; cap_awaddr = p_awaddr; cap_awprot = p_awprot;
         check("awvalid_drop", mem_axi_awvalid, 0);
      end else if (p_awv) begin
         check("awvalid_held", mem_axi_awvalid, 1);
         check("awaddr_stable", mem_axi_awaddr, p_awaddr);
      end
      if (p_wv && p_wr) begin
         w_done = 1; w_hs++; cap_wdata = p_wdata; cap_wstrb = p_wstrb;
         check("wvalid_drop", mem_axi_wvalid, 0);
      end else if (p_wv) begin
         check("wvalid_held", mem_axi_wvalid, 1);
         check("wdata_stable", mem_axi_wdata, p_wdata);
      end
      if (p_arv && p_arr) begin
         ar_done = 1; ar_hs++; cap_araddr = p_araddr; cap_arprot = p_arprot;
         check("arvalid_drop", mem_axi_arvalid, 0);
      end else if (p_arv) begin
         check("arvalid_held", mem_axi_arvalid, 1);
         check("araddr_stable", mem_axi_araddr, p_araddr);
      end
      if (p_bv && p_br) begin b_hs++; b_sent = 1; mem_axi_bvalid = 0; end
      if (p_rv && p_rr) begin r_hs++; r_sent = 1; mem_axi_rvalid = 0; end
      if (aw_done && w_done && !b_sent && !mem_axi_bvalid) begin
         if (b_n >= b_d) begin
            mem_axi_bvalid = 1;
            for (int b = 0; b < 4; b++)
               if (cap_wstrb[b]) smem[cap_awaddr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
         end else b_n++;
      end
      if (ar_done && !r_sent && !mem_axi_rvalid) begin
         if (r_n >= r_d) begin
            mem_axi_rvalid = 1; mem_axi_rdata = smem[cap_araddr[5:2]];
         end else r_n++;
      end
      mem_axi_awready = mem_axi_awvalid && aw_n >= aw_d; if (mem_axi_awvalid) aw_n++;
      mem_axi_wready  = mem_axi_wvalid  && w_n  >= w_d;  if (mem_axi_wvalid)  w_n++;
      mem_axi_arready = mem_axi_arvalid && ar_n >= ar_d; if (mem_axi_arvalid) ar_n++;
      p_awv = mem_axi_awvalid; p_awr = mem_axi_awready; p_awaddr = mem_axi_awaddr; p_awprot = mem_axi_awprot;
      p_wv = mem_axi_wvalid; p_wr = mem_axi_wready; p_wdata = mem_axi_wdata; p_wstrb = mem_axi_wstrb;
      p_arv = mem_axi_arvalid; p_arr = mem_axi_arready; p_araddr = mem_axi_araddr; p_arprot = mem_axi_arprot;
      p_bv = mem_axi_bvalid; p_br = mem_axi_bready; p_rv = mem_axi_rvalid; p_rr = mem_axi_rready;
   endtask

   // issue one native request at the current negedge; returns cycles until mem_ready is seen
   // and how many cycles mem_ready was high (including the cycle after the request is dropped)
   task automatic do_txn(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                         input bit ins, input int awd, input int wdd, input int bd, input int ard,
                         input int rd, output int cyc, output int rdy);
      slave_clear(awd, wdd, bd, ard, rd);
      mem_valid = 1; mem_addr = a; mem_wdata = wd; mem_wstrb = we ? st : 4'h0; mem_instr = ins;
      cyc = 0; rdy = 0;
      while (rdy == 0 && cyc < 200) begin
         @(negedge clk); slave_step(); cyc++;
         if (mem_ready) rdy++;
      end
      mem_valid = 0;
      @(negedge clk); slave_step();
      if (mem_ready) rdy++;
   endtask

   typedef struct {
      bit          we;
      logic [31:0] addr, wdata;
      logic [3:0]  wstrb;
      bit          instr;
      logic [31:0] word, exp_ax;
      logic [2:0]  exp_prot;
      logic [31:0] exp_rd;
      int          exp_cyc;
   } vec_t;

   vec_t vt [5];
   logic [31:0] ref_mem [16];
   logic [31:0] exp_last;

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: bench did not finish, %0d tests run", tests);
      $fatal(1);
   end

   initial begin
      int cyc, rdy;
      vt[0] = '{1'b0, 32'h0000_0104, 32'h0, 4'h0,    1'b1, 32'h1234_5678, 32'h0000_0104, 3'b100, 32'h1234_5678, 3};
      vt[1] = '{1'b1, 32'h0000_0203, 32'hAABB_CCDD, 4'b0011, 1'b0, 32'h0, 32'h0000_0200, 3'b000, 32'h1234_5678, 3};
      vt[2] = '{1'b0, 32'h0000_0206, 32'h0, 4'h0,    1'b0, 32'h0BAD_F00D, 32'h0000_0204, 3'b000, 32'h0BAD_F00D, 3};
      vt[3] = '{1'b1, 32'h0000_003C, 32'hDEAD_BEEF, 4'b1111, 1'b1, 32'h0, 32'h0000_003C, 3'b000, 32'h0BAD_F00D, 3};
      vt[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0,    1'b1, 32'hCAFE_0001, 32'hFFFF_FFFC, 3'b100, 32'hCAFE_0001, 3};
      for (int i = 0; i < 16; i++) smem[i] = '0;
      slave_clear(0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check("reset_valids", {mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_rready}, 0);
      check("reset_mem_ready", mem_ready, 0);
      check("reset_mem_rdata", mem_rdata, 0);
      check("reset_bus_err", bus_err, 0);
      resetn = 1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         if (!vt[i].we) smem[vt[i].addr[5:2]] = vt[i].word;
         do_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].instr, 0, 0, 0, 0, 0, cyc, rdy);
         check("vec_ready_once", rdy, 1);
         check("vec_cycles", cyc, vt[i].exp_cyc);
         check("vec_rdata", mem_rdata, vt[i].exp_rd);
         check("vec_hs_count", {aw_hs[3:0], w_hs[3:0], b_hs[3:0], ar_hs[3:0], r_hs[3:0]},
               vt[i].we ? 32'h11100 : 32'h00011);
         if (vt[i].we) begin
            check("vec_awaddr", cap_awaddr, vt[i].exp_ax);
            check("vec_awprot", cap_awprot, vt[i].exp_prot);
            check("vec_wdata", cap_wdata, vt[i].wdata);
            check("vec_wstrb", cap_wstrb, vt[i].wstrb);
         end else begin
            check("vec_araddr", cap_araddr, vt[i].exp_ax);
            check("vec_arprot", cap_arprot, vt[i].exp_prot);
         end
      end

      // wready four cycles ahead of awready: wvalid retires alone, awvalid must stay up
      do_txn(1, 32'h0000_0203, 32'h5566_7788, 4'b0011, 0, 4, 0, 0, 0, 0, cyc, rdy);
      check("split_ready_once", rdy, 1);
      check("split_cycles", cyc, 7);
      check("split_awaddr", cap_awaddr, 32'h0000_0200);
      check("split_hs_count", {aw_hs[3:0], w_hs[3:0], b_hs[3:0]}, 12'h111);
      check("split_rdata_held", mem_rdata, 32'hCAFE_0001);

      // reset while waiting for read data
      slave_clear(0, 0, 0, 0, 1000);
      mem_valid = 1; mem_addr = 32'h10; mem_wstrb = 0; mem_instr = 0;
      for (int k = 0; k < 20 && !mem_axi_rready; k++) begin @(negedge clk); slave_step(); end
      check("rst_reached_rdata", mem_axi_rready, 1);
      mem_valid = 0;
      #2 resetn = 0;
      #1;
      check("rst_async_valids", {mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_rready}, 0);
      check("rst_async_ready", mem_ready, 0);
      check("rst_async_rdata", mem_rdata, 0);
      @(negedge clk); resetn = 1;
      slave_clear(0, 0, 0, 0, 0);
      @(negedge clk);
      smem[4] = 32'h7777_0001;
      do_txn(0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, cyc, rdy);
      check("rst_after_ready_once", rdy, 1);
      check("rst_after_cycles", cyc, 3);
      check("rst_after_rdata", mem_rdata, 32'h7777_0001);
      exp_last = 32'h7777_0001;

      // random traffic against a plain word-memory reference
      for (int i = 0; i < 16; i++) begin ref_mem[i] = $urandom; smem[i] = ref_mem[i]; end
      for (int t = 0; t < 1000; t++) begin
         bit we = $urandom_range(0, 1);
         logic [31:0] a = $urandom, wd = $urandom;
         logic [3:0] st = 4'($urandom_range(1, 15));
         bit ins = $urandom_range(0, 1);
         do_txn(we, a, wd, st, ins, $urandom_range(0, MAXD), $urandom_range(0, MAXD), $urandom_range(0, MAXD),
                $urandom_range(0, MAXD), $urandom_range(0, MAXD), cyc, rdy);
         check("rnd_ready_once", rdy, 1);
         if (we) begin
            for (int b = 0; b < 4; b++) if (st[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
            check("rnd_awaddr", cap_awaddr, a & 32'hFFFF_FFFC);
            check("rnd_wdata", cap_wdata, wd);
            check("rnd_wstrb", cap_wstrb, st);
            check("rnd_hs_count", {aw_hs[3:0], w_hs[3:0], b_hs[3:0], ar_hs[3:0], r_hs[3:0]}, 32'h11100);
         end else begin
            exp_last = ref_mem[a[5:2]];
            check("rnd_araddr", cap_araddr, a & 32'hFFFF_FFFC);
            check("rnd_arprot", cap_arprot, ins ? 3'b100 : 3'b000);
            check("rnd_hs_count", {aw_hs[3:0], w_hs[3:0], b_hs[3:0], ar_hs[3:0], r_hs[3:0]}, 32'h00011);
         end
         check("rnd_rdata", mem_rdata, exp_last);
      end

`ifdef MEM_AXI_TIMEOUT_EN
      do_txn(0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 100000, cyc, rdy);
      check("to_ready_once", rdy, 1);
      check("to_cycles", cyc, TO + 1);
      check("to_rdata_fill", mem_rdata, 32'hFFFF_FFFF);
      check("to_bus_err", bus_err, 1);
      check("to_rready_dropped", mem_axi_rready, 0);
      smem[5] = 32'h5A5A_0005;
      do_txn(0, 32'h14, 0, 0, 0, 0, 0, 0, 0, 0, cyc, rdy);
      check("to_next_rdata", mem_rdata, 32'h5A5A_0005);
      check("to_bus_err_sticky", bus_err, 1);
      #2 resetn = 0;
      #1 check("to_bus_err_reset", bus_err, 0);
      @(negedge clk); resetn = 1;
`else
      check("bus_err_tied", bus_err, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
